// File: rtl/tiger_irq_ctrl.sv
// tiger_irq_ctrl: shares the Tiger CPU interrupt line among N_SRC edge-triggered sources.
// Sources latch as pending; a round-robin scheduler grants one at a time until EOI is written.
module tiger_irq_ctrl #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_SRC-1:0]  irq_src,
  input  logic [2:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              cpu_irq,
  output logic [ID_W-1:0]   irq_id
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ASSERT = 1'b1;

  localparam logic [2:0] A_PENDING = 3'd0;
  localparam logic [2:0] A_MASK    = 3'd1;
  localparam logic [2:0] A_ACTIVE  = 3'd2;
  localparam logic [2:0] A_EOI     = 3'd3;
  localparam logic [2:0] A_SOFT    = 3'd4;

  logic [N_SRC-1:0] sync1_r;
  logic [N_SRC-1:0] sync2_r;
  logic [N_SRC-1:0] dly_r;
  logic [N_SRC-1:0] pending_r;
  logic [N_SRC-1:0] mask_r;
  logic [1:0]       warm_r;
  logic [0:0]       state_r;
  logic [ID_W-1:0]  rr_ptr_r;

  logic [N_SRC-1:0] wdata_s;
  logic [N_SRC-1:0] rise_s;
  logic [N_SRC-1:0] set_s;
  logic [N_SRC-1:0] w1c_s;
  logic [N_SRC-1:0] claim_s;
  logic [N_SRC-1:0] cand_s;
  logic [ID_W:0]    pick_s;
  logic             grant_s;
  logic             eoi_s;
  logic [ID_W-1:0]  next_ptr_s;
  logic [31:0]      rd_s;
  logic             unused_wdata_s;

  // Returns {found, id} of the first candidate at or above ptr, wrapping mod N_SRC.
  function automatic logic [ID_W:0] rr_pick(input logic [N_SRC-1:0] cand,
                                            input logic [ID_W-1:0]  ptr);
    logic [ID_W:0] res;
    int            idx;
    res = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_SRC) begin
        idx = idx - N_SRC;
      end
      if (cand[idx]) begin
        res = {1'b1, ID_W'(idx)};
      end
    end
    return res;
  endfunction

  assign unused_wdata_s = ^avs_writedata;

  // Pending next-state terms and scheduler decisions.
  always_comb begin
    wdata_s = avs_writedata[N_SRC-1:0];
    // Edges are ignored until the synchroniser chain holds post-reset samples,
    // so a level held high across reset does not fire.
    if (warm_r == 2'd3) begin
      rise_s = sync2_r & ~dly_r;
    end else begin
      rise_s = '0;
    end
    if (avs_write && (avs_address == A_SOFT)) begin
      set_s = rise_s | wdata_s;
    end else begin
      set_s = rise_s;
    end
    if (avs_write && (avs_address == A_PENDING)) begin
      w1c_s = wdata_s;
    end else begin
      w1c_s = '0;
    end
    cand_s  = pending_r & mask_r;
    pick_s  = rr_pick(cand_s, rr_ptr_r);
    grant_s = (state_r == IDLE) && pick_s[ID_W];
    if (grant_s) begin
      claim_s = {{(N_SRC-1){1'b0}}, 1'b1} << pick_s[ID_W-1:0];
    end else begin
      claim_s = '0;
    end
    eoi_s = (state_r == ASSERT) && avs_write && (avs_address == A_EOI);
    if (irq_id == ID_W'(N_SRC - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = irq_id + ID_W'(1);
    end
  end

  // Register read mux; unmapped words read zero.
  always_comb begin
    rd_s = 32'd0;
    case (avs_address)
      A_PENDING: rd_s[N_SRC-1:0] = pending_r;
      A_MASK:    rd_s[N_SRC-1:0] = mask_r;
      A_ACTIVE: begin
        rd_s[31]       = cpu_irq;
        rd_s[ID_W-1:0] = irq_id;
      end
      default:   rd_s = 32'd0;
    endcase
  end

  // Two-flop synchroniser, edge-detect delay flop and post-reset warm-up count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= '0;
      sync2_r <= '0;
      dly_r   <= '0;
      warm_r  <= 2'd0;
    end else begin
      sync1_r <= irq_src;
      sync2_r <= sync1_r;
      dly_r   <= sync2_r;
      if (warm_r != 2'd3) begin
        warm_r <= warm_r + 2'd1;
      end
    end
  end

  // Set beats both W1C and the grant claim on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_r <= '0;
    end else begin
      pending_r <= (pending_r & ~w1c_s & ~claim_s) | set_s;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_r <= '0;
    end else if (avs_write && (avs_address == A_MASK)) begin
      mask_r <= wdata_s;
    end
  end

  // Scheduler: grant from IDLE, hold in ASSERT until EOI.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      cpu_irq  <= 1'b0;
      irq_id   <= '0;
      rr_ptr_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            state_r <= ASSERT;
            cpu_irq <= 1'b1;
            irq_id  <= pick_s[ID_W-1:0];
          end
        end
        ASSERT: begin
          if (eoi_s) begin
            state_r  <= IDLE;
            cpu_irq  <= 1'b0;
            rr_ptr_r <= next_ptr_s;
          end
        end
        default: begin
          state_r <= IDLE;
          cpu_irq <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= 32'd0;
    end else if (avs_read) begin
      avs_readdata <= rd_s;
    end
  end

endmodule
